// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch responder for the 16-bit core.
// Serves fetch requests on cp from a 2^ADDR_W x 16 instruction memory with a
// MEM_LAT-cycle read latency, and returns the word on ri with a one-cycle
// ri_valid pulse. The memory is loaded through the prog_* write port.
// Optional feature: define INSTR_FETCH_PREFETCH_EN to add a one-entry
// sequential prefetch buffer (PREFETCH state, hit and merge paths). Without
// it every request takes the demand path and latency is always MEM_LAT+1.
module instr_fetch #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [15:0]       cp,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  output logic [15:0]       ri,
  output logic              ri_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FETCH    = 2'd1,
    S_PREFETCH = 2'd2
  } state_t;

  localparam logic [3:0] LAT   = 4'(MEM_LAT);
  localparam int         DEPTH = 1 << ADDR_W;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ri_q, ri_d;
  logic        ri_valid_q, ri_valid_d;
  logic        deliver;
  logic        cnt_done;
  logic [15:0] mem_rd;
  logic [15:0] mem_q [DEPTH];

`ifdef INSTR_FETCH_PREFETCH_EN
  logic        pvalid_q, pvalid_d;
  logic [15:0] paddr_q, paddr_d;
  logic [15:0] pdata_q, pdata_d;
  logic        hit;
  logic        merge;

  // A hit needs the full 16-bit address to match, not just the memory index.
  assign hit   = pvalid_q && (cp == paddr_q);
  assign merge = (cp == addr_q);
`else
  // Upper address bits only matter for buffer hits, which this build lacks.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q;
`endif

  // The read is sampled on the completion edge, so it always sees the most
  // recent loader write that landed before that edge.
  assign mem_rd   = mem_q[addr_q[ADDR_W-1:0]];
  assign cnt_done = (cnt_q == 4'd1);

  assign ri       = ri_q;
  assign ri_valid = ri_valid_q;
  assign busy     = (state_q == S_FETCH);

  // Loader write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state, response and buffer control; flush overrides the FSM but not loader writes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    ri_d       = ri_q;
    ri_valid_d = 1'b0;
    deliver    = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
    pvalid_d   = pvalid_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
`endif

    if (flush) begin
      // Taken jump: drop everything in flight, including a same-cycle req.
      state_d = S_IDLE;
      cnt_d   = 4'd0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pvalid_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
`ifdef INSTR_FETCH_PREFETCH_EN
            if (hit) begin
              ri_d       = pdata_q;
              ri_valid_d = 1'b1;
              pvalid_d   = 1'b0;
              addr_d     = cp + 16'd1;
              cnt_d      = LAT;
              state_d    = S_PREFETCH;
            end else begin
              addr_d  = cp;
              cnt_d   = LAT;
              state_d = S_FETCH;
            end
`else
            addr_d  = cp;
            cnt_d   = LAT;
            state_d = S_FETCH;
`endif
          end
        end

        S_FETCH: begin
          if (cnt_done) begin
            deliver = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

`ifdef INSTR_FETCH_PREFETCH_EN
        S_PREFETCH: begin
          if (req && merge) begin
            // The demand wants the word already in flight: keep the timer.
            if (cnt_done) begin
              deliver = 1'b1;
            end else begin
              cnt_d   = cnt_q - 4'd1;
              state_d = S_FETCH;
            end
          end else if (req) begin
            // Wrong guess: abandon the prefetch and serve the demand miss.
            addr_d  = cp;
            cnt_d   = LAT;
            state_d = S_FETCH;
          end else if (cnt_done) begin
            pdata_d  = mem_rd;
            paddr_d  = addr_q;
            pvalid_d = 1'b1;
            cnt_d    = 4'd0;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
`endif

        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase

      // Demand read finished: respond, then speculate on the next sequential word.
      if (deliver) begin
        ri_d       = mem_rd;
        ri_valid_d = 1'b1;
`ifdef INSTR_FETCH_PREFETCH_EN
        addr_d     = addr_q + 16'd1;
        cnt_d      = LAT;
        state_d    = S_PREFETCH;
        pvalid_d   = 1'b0;
`else
        cnt_d      = 4'd0;
        state_d    = S_IDLE;
`endif
      end
    end

`ifdef INSTR_FETCH_PREFETCH_EN
    // A loader write to the buffered index makes the buffered copy stale;
    // compare against the address the buffer will hold after this edge.
    if (prog_we && (prog_addr == paddr_d[ADDR_W-1:0])) begin
      pvalid_d = 1'b0;
    end
`endif
  end

  // Control state with asynchronous active-low reset; reset abandons any read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ri_q       <= 16'h0000;
      ri_valid_q <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
      pvalid_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ri_q       <= ri_d;
      ri_valid_q <= ri_valid_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      pvalid_q   <= pvalid_d;
`endif
    end
  end

  // Address and buffer data are only meaningful under the control flags above.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
`ifdef INSTR_FETCH_PREFETCH_EN
    paddr_q <= paddr_d;
    pdata_q <= pdata_d;
`endif
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test-plan sequences followed by randomized traffic,
// all checked every cycle against a transaction-level reference model that
// tracks the in-flight read by its absolute completion cycle.
module tb_instr_fetch;

  localparam int AW  = 8;
  localparam int LAT = 2;
`ifdef INSTR_FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  // Latency of a request whose word sits in the buffer (or would, with prefetch).
  localparam int HIT_LAT = PF ? 1 : LAT + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [15:0]   cp;
  logic          flush;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic [15:0]   ri;
  logic          ri_valid;
  logic          busy;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cp        (cp),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ri        (ri),
    .ri_valid  (ri_valid),
    .busy      (busy)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          rv_cyc   = -1;
  logic [15:0] rv_data  = 16'h0000;
  int          c0;

  // Reference model state
  logic [15:0] m_mem [256];
  int          m_kind;   // 0: nothing in flight, 1: demand read, 2: prefetch read
  logic [15:0] m_addr;
  int          m_done;   // cycle whose closing edge completes the read
  bit          m_pv;
  logic [15:0] m_pa;
  logic [15:0] m_pd;
  logic [15:0] m_ri;
  bit          m_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_kind = 0;
    m_addr = 16'h0000;
    m_done = 0;
    m_pv   = 1'b0;
    m_pa   = 16'h0000;
    m_pd   = 16'h0000;
    m_ri   = 16'h0000;
    m_rv   = 1'b0;
  endtask

  task automatic model_start_pf(input logic [15:0] a, input int t);
    m_kind = 2;
    m_addr = a;
    m_done = t + LAT;
    m_pv   = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit rq, input logic [15:0] a, input bit fl,
                      input bit we, input logic [AW-1:0] wa, input logic [15:0] wd);
    bit          rv_n;
    logic [15:0] ri_n;
    logic [15:0] rd;
    int          k0;
    req = rq; cp = a; flush = fl; prog_we = we; prog_addr = wa; prog_data = wd;
    check("ri", 32'(ri), 32'(m_ri));
    check("ri_valid", 32'(ri_valid), 32'(m_rv));
    check("busy", 32'(busy), 32'(m_kind == 1));
    if (ri_valid === 1'b1) begin
      rv_cyc  = cyc;
      rv_data = ri;
    end
    rv_n = 1'b0;
    ri_n = m_ri;
    k0   = m_kind;
    rd   = m_mem[m_addr[AW-1:0]];
    if (fl) begin
      m_kind = 0;
      m_pv   = 1'b0;
    end else if (k0 == 1) begin
      if (cyc == m_done) begin
        ri_n = rd;
        rv_n = 1'b1;
        if (PF) model_start_pf(m_addr + 16'd1, cyc);
        else m_kind = 0;
      end
    end else if (k0 == 2) begin
      if (rq && a == m_addr) begin
        if (cyc == m_done) begin
          ri_n = rd;
          rv_n = 1'b1;
          model_start_pf(m_addr + 16'd1, cyc);
        end else begin
          m_kind = 1;
        end
      end else if (rq) begin
        m_kind = 1;
        m_addr = a;
        m_done = cyc + LAT;
      end else if (cyc == m_done) begin
        m_pv   = 1'b1;
        m_pa   = m_addr;
        m_pd   = rd;
        m_kind = 0;
      end
    end else if (rq) begin
      if (m_pv && a == m_pa) begin
        ri_n = m_pd;
        rv_n = 1'b1;
        model_start_pf(a + 16'd1, cyc);
      end else begin
        m_kind = 1;
        m_addr = a;
        m_done = cyc + LAT;
      end
    end
    if (we) begin
      if (m_pa[AW-1:0] == wa) m_pv = 1'b0;
      m_mem[wa] = wd;
    end
    m_ri = ri_n;
    m_rv = rv_n;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [15:0] wd);
    step(1'b0, 16'h0000, 1'b0, 1'b1, wa, wd);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=%0d cycles expected=finish", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0; req = 1'b0; cp = 16'h0000; flush = 1'b0;
    prog_we = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_ri", 32'(ri), 32'h0);
    check("por_ri_valid", 32'(ri_valid), 32'h0);
    check("por_busy", 32'(busy), 32'h0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Preload the whole memory so every read has a known value.
    for (int i = 0; i < 256; i++) wr(8'(i), 16'($urandom));
    idle(2);

    // Reset in the middle of a demand fetch.
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(1);
    #2 rst = 1'b0;
    #1;
    check("rst_ri", 32'(ri), 32'h0);
    check("rst_ri_valid", 32'(ri_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rv_cyc = -1;
    c0 = cyc;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(5);
    check("post_rst_lat", 32'(rv_cyc), 32'(c0 + LAT + 1));

    // Miss then sequential hit.
    idle(4);
    wr(8'h05, 16'h1234);
    wr(8'h06, 16'h5678);
    idle(1);
    c0 = cyc;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("miss_lat", 32'(rv_cyc), 32'(c0 + LAT + 1));
    check("miss_data", 32'(rv_data), 32'h1234);
    step(1'b1, 16'h0006, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("hit_lat", 32'(rv_cyc), 32'(c0 + 5 + HIT_LAT));
    check("hit_data", 32'(rv_data), 32'h5678);

    // Request for the word being prefetched merges with it.
    idle(4);
    c0 = cyc;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(3);
    step(1'b1, 16'h0006, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("merge_lat", 32'(rv_cyc), 32'(c0 + 4 + HIT_LAT));
    check("merge_data", 32'(rv_data), 32'h5678);

    // Loader write lands while the prefetch of that index is in flight.
    idle(4);
    c0 = cyc;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(2);
    wr(8'h06, 16'hAAAA);
    idle(2);
    step(1'b1, 16'h0006, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("wr_pf_lat", 32'(rv_cyc), 32'(c0 + 6 + HIT_LAT));
    check("wr_pf_data", 32'(rv_data), 32'hAAAA);
    // Writing the buffered index invalidates the buffer: next request misses.
    idle(3);
    wr(8'h07, 16'hBBBB);
    c0 = cyc;
    step(1'b1, 16'h0007, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("wr_inv_lat", 32'(rv_cyc), 32'(c0 + LAT + 1));
    check("wr_inv_data", 32'(rv_data), 32'hBBBB);

    // Flush during a miss, and a request dropped by a simultaneous flush.
    idle(4);
    rv_cyc = -1;
    step(1'b1, 16'h0005, 1'b0, 1'b0, 8'h00, 16'h0000);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000);
    check("flush_busy", 32'(busy), 32'h0);
    idle(5);
    check("flush_no_rv", 32'(rv_cyc), 32'hFFFF_FFFF);
    step(1'b1, 16'h0005, 1'b1, 1'b0, 8'h00, 16'h0000);
    idle(5);
    check("flush_req_drop", 32'(rv_cyc), 32'hFFFF_FFFF);

    // Address increment wraps from 0xFFFF to 0x0000.
    idle(2);
    c0 = cyc;
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("wrap_miss_lat", 32'(rv_cyc), 32'(c0 + LAT + 1));
    check("wrap_miss_data", 32'(rv_data), 32'(m_mem[255]));
    step(1'b1, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    idle(4);
    check("wrap_hit_lat", 32'(rv_cyc), 32'(c0 + 5 + HIT_LAT));
    check("wrap_hit_data", 32'(rv_data), 32'(m_mem[0]));

    // Randomized traffic concentrated on a few indices so hits, merges,
    // aborts, stale-buffer writes and wrap-around all occur.
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] wa;
      lo = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(250, 255));
      case ($urandom_range(0, 5))
        0:       hi = 8'($urandom);
        1:       hi = 8'hFF;
        default: hi = 8'h00;
      endcase
      wa = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(250, 255));
      step(1'($urandom_range(0, 1)), {hi, lo}, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), wa, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch responder for the 16-bit core: accepts a fetch request carrying the program counter (`cp`) and returns the 16-bit instruction word (`ri`) that the core decodes. It holds a `2^ADDR_W` x 16 instruction memory with a programmable read latency, a loader write port and an optional one-entry sequential prefetch buffer. It sits between the core's `CP` output and its `RI` input.

## Interface
- `ADDR_W`, default 8: instruction memory index width; depth is `2^ADDR_W` words.
- `MEM_LAT`, default 2: memory read latency in cycles; legal range 1..15.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `req`  in  1: fetch request; sampled only while `busy`=0.
- `cp`  in  16: fetch address; the memory index is `cp[ADDR_W-1:0]` and the upper bits are ignored.
- `flush`  in  1: on a taken jump, abort any in-flight fetch or prefetch and invalidate the buffer.
- `prog_we`  in  1: loader write enable.
- `prog_addr`  in  ADDR_W: loader write index.
- `prog_data`  in  16: loader write data.
- `ri`  out  16: instruction word; holds its last value between responses.
- `ri_valid`  out  1: one-cycle pulse marking `ri` as a new response.
- `busy`  out  1: a demand fetch is outstanding; `req` is ignored while high.

## Operation
- States: IDLE, FETCH (demand read), PREFETCH (background read of the last address + 1).
- A down-counter loaded with `MEM_LAT` times every read. The memory word is sampled on the edge where the counter expires, so the read returns the most recent contents at completion.
- IDLE, `req`=1:
  - Hit (`pvalid` and `cp`==`paddr`): `ri`<=`pdata`, pulse `ri_valid`, clear `pvalid`, start a prefetch of `cp`+1, go to PREFETCH.
  - Miss: latch `cp`, go to FETCH.
- FETCH, on completion: `ri`<=mem, pulse `ri_valid`, start a prefetch of addr+1, go to PREFETCH.
- PREFETCH, on completion: `pdata`/`paddr` loaded, `pvalid`=1, go to IDLE.
- PREFETCH, `req`=1:
  - If `cp` equals the in-flight address, the request merges: go to FETCH and keep the remaining count.
  - Otherwise the prefetch is aborted and the request is handled as an IDLE miss.
- `flush`=1, any state: go to IDLE, clear `pvalid`, suppress any pending `ri_valid`. A `req` in the same cycle is dropped, because `flush` has priority.
- `prog_we`: the memory is written on the edge. If `prog_addr` matches `paddr[ADDR_W-1:0]`, clear `pvalid`.
- Address increment is 16-bit and wraps: 16'hFFFF + 1 = 16'h0000.
- `busy`=1 exactly while in FETCH.
- Reset (`rst`=0): state IDLE, `ri`=0, `ri_valid`=0, `busy`=0, `pvalid`=0, counter cleared. Reset mid-fetch discards the fetch. Memory contents are not reset.

## Timing
- Miss: `req` sampled in cycle 0, `busy` high in cycles 1..`MEM_LAT`, `ri_valid` in cycle `MEM_LAT`+1.
- Hit: `req` in cycle 0, `ri_valid` in cycle 1.
- Prefetch starts in the cycle `ri_valid` is high and completes `MEM_LAT` cycles later.
- A merged request is delivered one cycle after the original prefetch completion edge.
- Write-then-read to the same index in consecutive cycles returns the new data.

## Configuration
- `INSTR_FETCH_PREFETCH_EN` defined: prefetch buffer and PREFETCH state are present, as described above.
- Not defined: there is no buffer, every request takes the miss path, completion returns to IDLE, and merge/hit logic is absent. Latency is always `MEM_LAT`+1.

## Test plan
- Reset with `rst`=0 mid-FETCH -> `ri`=0, `ri_valid`=0, `busy`=0. After release, `req` `cp`=0x0005 -> `ri_valid` in cycle 3 with `MEM_LAT`=2.
- Load mem[5]=0x1234 and mem[6]=0x5678. `req` 5 (miss) -> 0x1234 in cycle 3. `req` 6 in cycle 5 (hit) -> 0x5678 in cycle 6.
- `req` 5 in cycle 0, `req` 6 in cycle 4 (merge) -> 0x5678 with `ri_valid` in cycle 5.
- Start a prefetch of 6, then `prog_we` index 6 = 0xAAAA before it completes -> `req` 6 returns 0xAAAA. `prog_we` to the buffered index clears `pvalid`, so the next `req` takes the miss path.
- `flush` in cycle 1 of a miss -> no `ri_valid`, `busy`=0 in cycle 2. A `req` asserted together with `flush` gets no response.
- `req` `cp`=0xFFFF -> prefetch targets 0x0000, and `req` 0x0000 then hits in 1 cycle.
